// File: rtl/term_cursor_ctrl.sv
// term_cursor_ctrl: terminal cursor tracking and character-RAM write controller
// with scroll/wrap on overflow and multi-cycle line/screen clear.
module term_cursor_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 48,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int TAB_W  = 8,
  parameter int SCROLL = 1,
  parameter logic [DATA_W-1:0] BLANK = DATA_W'(8'h20),
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [2:0]        key_op,
  input  logic [DATA_W-1:0] key_code,
  output logic              key_ready,
  output logic              key_drop,
  output logic              busy,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic [RW-1:0]     scroll_base,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d, base_q, base_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, line_q, line_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, drop_q, drop_d, nl, last;
  logic [31:0] tab_n;

  // Physical row wraps by compare-and-subtract so non-power-of-2 ROWS work.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                                input logic [RW-1:0] b);
    logic [RW:0] p;
    p = {1'b0, r} + {1'b0, b};
    if (p >= (RW+1)'(ROWS)) p = p - (RW+1)'(ROWS);
    return ADDR_W'(32'(p) * 32'(COLS) + 32'(c));
  endfunction

  assign tab_n = 32'(col_q) - 32'(col_q) % 32'(TAB_W) + 32'(TAB_W);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = key_valid && state_q != IDLE;
    nl        = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: if (key_valid) begin
        case (key_op)
          3'd0: begin
            wr_en_d   = 1'b1;
            wr_data_d = key_code;
            nl        = col_q == CW'(COLS-1);
            col_d     = nl ? '0 : col_q + CW'(1);
          end
          3'd1: begin
            col_d = '0;
            nl    = 1'b1;
          end
          3'd2: begin
            nl    = tab_n >= 32'(COLS);
            col_d = nl ? '0 : CW'(tab_n);
          end
          3'd3: if (col_q != '0) begin
            col_d     = col_q - CW'(1);
            wr_en_d   = 1'b1;
            wr_data_d = BLANK;
          end else if (row_q != '0) begin
            row_d     = row_q - RW'(1);
            col_d     = CW'(COLS-1);
            wr_en_d   = 1'b1;
            wr_data_d = BLANK;
          end
          3'd4: col_d = col_q == CW'(COLS-1) ? col_q : col_q + CW'(1);
          3'd5: col_d = col_q == '0 ? col_q : col_q - CW'(1);
          3'd6: begin
            col_d = '0;
            row_d = '0;
          end
          default: begin
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            cnt_d   = '0;
            state_d = CLR_ALL;
          end
        endcase
        // The line scrolled in is the old logical row 0, i.e. physical row base_q.
        if (nl) begin
          if (row_q != RW'(ROWS-1)) row_d = row_q + RW'(1);
          else if (SCROLL != 0) begin
            base_d  = base_q == RW'(ROWS-1) ? '0 : base_q + RW'(1);
            line_d  = addr_of('0, '0, base_q);
            cnt_d   = '0;
            state_d = CLR_LINE;
          end else row_d = '0;
        end
        if (wr_en_d) wr_addr_d = key_op == 3'd0 ? addr_of(col_q, row_q, base_q) : addr_of(col_d, row_d, base_q);
      end
      default: begin
        wr_en_d   = 1'b1;
        wr_data_d = BLANK;
        wr_addr_d = state_q == CLR_LINE ? line_q + cnt_q : cnt_q;
        last      = state_q == CLR_LINE ? cnt_q == ADDR_W'(COLS-1) : cnt_q == ADDR_W'(COLS*ROWS-1);
        cnt_d     = last ? '0 : cnt_q + ADDR_W'(1);
        state_d   = last ? IDLE : state_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      line_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

  assign key_ready   = state_q == IDLE;
  assign busy        = !key_ready;
  assign key_drop    = drop_q;
  assign col         = col_q;
  assign row         = row_q;
  assign scroll_base = base_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
endmodule

// File: tb/tb_term_cursor_ctrl.sv
// tb_term_cursor_ctrl: directed checks of term_cursor_ctrl at default 80x48 geometry.
module tb_term_cursor_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0;
  logic [2:0] key_op = '0;
  logic [7:0] key_code = '0;
  logic key_ready, key_drop, busy, wr_en;
  logic [6:0] col;
  logic [5:0] row, scroll_base;
  logic [11:0] wr_addr;
  logic [7:0] wr_data;
  int total = 0, bad = 0, nerr;

  localparam logic [2:0] PUT = 3'd0, ENTER = 3'd1, TAB = 3'd2, BS = 3'd3,
                         CUF = 3'd4, CUB = 3'd5, HOME = 3'd6, CLEAR = 3'd7;

  term_cursor_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_op(key_op), .key_code(key_code),
    .key_ready(key_ready), .key_drop(key_drop), .busy(busy), .col(col), .row(row),
    .scroll_base(scroll_base), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic [2:0] op, input logic [7:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_op    = op;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_col"}, 32'(col), 0);
    chk({tag, "_row"}, 32'(row), 0);
    chk({tag, "_base"}, 32'(scroll_base), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_drop"}, 32'(key_drop), 0);
    chk({tag, "_ready"}, 32'(key_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #12;
    chk_idle_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    ev(PUT, 8'h41);
    chk("put_en", 32'(wr_en), 1);
    chk("put_addr", 32'(wr_addr), 0);
    chk("put_data", 32'(wr_data), 32'h41);
    chk("put_col", 32'(col), 1);
    chk("put_row", 32'(row), 0);
    cyc();
    chk("put_en_pulse", 32'(wr_en), 0);
    ev(HOME, 0);
    for (int i = 0; i < 80; i++) ev(PUT, 8'(i));
    chk("put80_en", 32'(wr_en), 1);
    chk("put80_addr", 32'(wr_addr), 79);
    chk("put80_col", 32'(col), 0);
    chk("put80_row", 32'(row), 1);
    ev(HOME, 0);
    for (int i = 0; i < 5; i++) ev(CUF, 0);
    ev(TAB, 0);
    chk("tab5_col", 32'(col), 8);
    chk("tab5_en", 32'(wr_en), 0);
    ev(HOME, 0);
    for (int i = 0; i < 3; i++) ev(ENTER, 0);
    for (int i = 0; i < 77; i++) ev(CUF, 0);
    chk("cuf77_col", 32'(col), 77);
    ev(TAB, 0);
    chk("tab77_col", 32'(col), 0);
    chk("tab77_row", 32'(row), 4);
    chk("tab77_en", 32'(wr_en), 0);
    for (int i = 0; i < 82; i++) ev(CUF, 0);
    chk("cuf_sat", 32'(col), 79);
    for (int i = 0; i < 82; i++) ev(CUB, 0);
    chk("cub_sat", 32'(col), 0);
    ev(HOME, 0);
    ev(ENTER, 0);
    ev(BS, 0);
    chk("bs01_col", 32'(col), 79);
    chk("bs01_row", 32'(row), 0);
    chk("bs01_en", 32'(wr_en), 1);
    chk("bs01_addr", 32'(wr_addr), 79);
    chk("bs01_data", 32'(wr_data), 32'h20);
    ev(BS, 0);
    chk("bs_col_dec", 32'(col), 78);
    chk("bs_addr_dec", 32'(wr_addr), 78);
    ev(HOME, 0);
    ev(BS, 0);
    chk("bs00_en", 32'(wr_en), 0);
    chk("bs00_col", 32'(col), 0);
    chk("bs00_row", 32'(row), 0);
    for (int i = 0; i < 47; i++) ev(ENTER, 0);
    chk("row47", 32'(row), 47);
    ev(ENTER, 0);
    chk("scr_base", 32'(scroll_base), 1);
    chk("scr_row", 32'(row), 47);
    chk("scr_col", 32'(col), 0);
    chk("scr_busy", 32'(busy), 1);
    chk("scr_ready", 32'(key_ready), 0);
    chk("scr_en0", 32'(wr_en), 0);
    for (int i = 0; i < 80; i++) begin
      cyc();
      chk($sformatf("scr_addr%0d", i), 32'(wr_addr), 32'(i));
      chk($sformatf("scr_en%0d", i), {wr_en, wr_data}, 32'h120);
      if (i < 79) chk($sformatf("scr_busy%0d", i), 32'(busy), 1);
      if (i == 10) begin
        key_valid = 1'b1;
        key_op    = PUT;
        key_code  = 8'h55;
      end
      if (i == 11) begin
        chk("drop_pulse", 32'(key_drop), 1);
        key_valid = 1'b0;
      end
      if (i == 12) chk("drop_clear", 32'(key_drop), 0);
    end
    chk("scr_done_ready", 32'(key_ready), 1);
    chk("drop_no_effect", {scroll_base, row, col}, {6'd1, 6'd47, 7'd0});
    ev(PUT, 8'h42);
    chk("scr_put_addr", 32'(wr_addr), 0);
    chk("scr_put_data", 32'(wr_data), 32'h42);
    chk("scr_put_col", 32'(col), 1);
    for (int i = 0; i < 78; i++) ev(CUF, 0);
    ev(PUT, 8'h43);
    chk("scr2_put_addr", 32'(wr_addr), 79);
    chk("scr2_put_data", 32'(wr_data), 32'h43);
    chk("scr2_base", 32'(scroll_base), 2);
    chk("scr2_pos", {row, col}, {6'd47, 7'd0});
    nerr = 0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if ({wr_en, wr_data, wr_addr} !== {1'b1, 8'h20, 12'(80 + i)}) nerr++;
    end
    chk("scr2_clear_writes", 32'(nerr), 0);
    chk("scr2_ready", 32'(key_ready), 1);
    ev(CLEAR, 0);
    chk("clr_pos", {scroll_base, row, col}, 0);
    chk("clr_busy", 32'(busy), 1);
    chk("clr_en0", 32'(wr_en), 0);
    nerr = 0;
    for (int i = 0; i < 3840; i++) begin
      cyc();
      if ({wr_en, wr_data, wr_addr} !== {1'b1, 8'h20, 12'(i)}) nerr++;
      if (i < 3839 && key_ready !== 1'b0) nerr++;
    end
    chk("clr_all_writes", 32'(nerr), 0);
    chk("clr_ready", 32'(key_ready), 1);
    cyc();
    chk("clr_en_off", 32'(wr_en), 0);
    ev(PUT, 8'h31);
    ev(ENTER, 0);
    ev(CLEAR, 0);
    for (int i = 0; i < 100; i++) cyc();
    chk("mid_clr_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk_idle_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    ev(PUT, 8'h44);
    chk("post_rst_put", {wr_en, wr_data, wr_addr}, {1'b1, 8'h44, 12'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
